// File: rtl/rr_address_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_address_arbiter
// Description : Four-way round-robin arbiter driving a 2-to-4 decoder
//               (address1/address0/enable), with break-before-make gap and
//               a bounded hold time per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_address_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       address0,
    output logic       address1,
    output logic       enable,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q,   state_d;
    logic [1:0] ptr_q,     ptr_d;
    logic [7:0] cnt_q,     cnt_d;
    logic [1:0] addr_q,    addr_d;
    logic       enable_q,  enable_d;
    logic       timeout_q, timeout_d;

    logic [7:0] w_req_dbl;
    logic [3:0] w_req_rot;
    logic [1:0] w_pick_ofs;
    logic [1:0] w_pick_idx;
    logic       w_any_req;
    logic       w_granted_req;
    logic       w_hold_expired;

    // Rotate so bit j of w_req_rot is requester (ptr + j) mod 4.
    assign w_req_dbl = {req, req};
    assign w_req_rot = w_req_dbl[ptr_q +: 4];
    assign w_any_req = |req;

    always_comb begin
        w_pick_ofs = 2'd0;
        casez (w_req_rot)
            4'b???1: w_pick_ofs = 2'd0;
            4'b??10: w_pick_ofs = 2'd1;
            4'b?100: w_pick_ofs = 2'd2;
            4'b1000: w_pick_ofs = 2'd3;
            default: w_pick_ofs = 2'd0;
        endcase
    end

    assign w_pick_idx     = ptr_q + w_pick_ofs;
    assign w_granted_req  = req[addr_q];
    assign w_hold_expired = (cnt_q == c_HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        enable_d  = enable_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                enable_d = 1'b0;
                if (w_any_req) begin
                    addr_d   = w_pick_idx;
                    enable_d = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ST_GRANT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (done || !w_granted_req || w_hold_expired) begin
                    enable_d  = 1'b0;
                    ptr_d     = addr_q + 2'd1;
                    state_d   = ST_GAP;
                    // Only a pure hold expiry is reported as a timeout.
                    timeout_d = !done && w_granted_req && w_hold_expired;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                enable_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            addr_q    <= 2'd0;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
        end
    end

    assign address0 = addr_q[0];
    assign address1 = addr_q[1];
    assign enable   = enable_q;
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: doc/rr_address_arbiter.md
RR_ADDRESS_ARBITER -- requirements
Module: rr_address_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one grant may hold enable high; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request vector; bit i high = requester i wants the decoder output selected.
REQ-005 Port: done  input  1  current grantee finished; sampled only in GRANT.
REQ-006 Port: address0  output  1  LSB of granted index; drives decoder address0.
REQ-007 Port: address1  output  1  MSB of granted index; drives decoder address1.
REQ-008 Port: enable  output  1  grant valid; drives decoder enable.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.
REQ-010 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-011 States SHALL be IDLE, GRANT and GAP, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next edge.
REQ-012 Internal state SHALL include a 2-bit round-robin pointer ptr and an 8-bit hold counter cnt.
REQ-013 Arbitration SHALL select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3, each modulo 4.
REQ-014 In IDLE with req==0: enable=0, address held at last value, state stays IDLE.
REQ-015 In IDLE with req!=0 at edge k: on edge k, {address1,address0} loads the selected index, enable goes 1, cnt goes 0, state goes GRANT.
REQ-016 Grant latency SHALL be exactly one edge from the first sampled request.
REQ-017 In GRANT, address SHALL be stable and enable SHALL be 1.
REQ-018 In GRANT, cnt increments by 1 per edge while no exit condition holds.
REQ-019 GRANT exit conditions, evaluated at each edge in this priority order: (a) done==1; (b) req[granted index]==0 (withdrawal); (c) cnt==MAX_HOLD-1 (timeout).
REQ-020 On any GRANT exit: enable goes 0, ptr goes granted index+1 modulo 4 (3 wraps to 0), state goes GAP.
REQ-021 timeout SHALL pulse high for exactly one cycle, coincident with the first GAP cycle, only when exit cause (c) applies and neither (a) nor (b) is true.
REQ-022 When MAX_HOLD==1, every grant SHALL last exactly one cycle.
REQ-023 GAP SHALL last exactly one cycle with enable=0 (break-before-make) and address unchanged.
REQ-024 GAP SHALL arbitrate as IDLE does, using the updated ptr: go to GRANT if req!=0, else to IDLE.
REQ-025 Consecutive grants SHALL therefore be separated by exactly one enable-low cycle.
REQ-026 address SHALL change only on an edge where enable transitions 0 to 1.
REQ-027 req changes on non-granted bits during GRANT SHALL have no effect until the next arbitration.
REQ-028 done outside GRANT SHALL be ignored.

Reset
REQ-029 While reset_n==0, regardless of clk: state=IDLE, enable=0, address0=0, address1=0, timeout=0, ptr=0, cnt=0.
REQ-030 Reset assertion mid-GRANT SHALL drop enable immediately (asynchronously), with no GAP cycle.
REQ-031 After reset_n deasserts, the first edge with req!=0 SHALL grant the lowest-index requester (ptr=0).

Verification
REQ-032 Single request: reset, req=0100 held, done pulsed on the 3rd GRANT cycle -> address=10 and enable=1 for 3 cycles; 1 GAP cycle; regrant to index 2 on the next edge.
REQ-033 Fairness: req=1111 held, done pulsed every grant -> grant order 0,1,2,3,0, each grant separated by one enable-low cycle.
REQ-034 Timeout with MAX_HOLD=8: req=0001 held, done=0 -> enable high exactly 8 cycles; timeout=1 for the one cycle after; regrant index 0 next.
REQ-035 done and timeout coinciding: done=1 on the 8th GRANT cycle -> timeout stays 0.
REQ-036 Pointer wrap and withdrawal: grant index 3, then req[3] drops -> release; req=1001 at GAP -> index 0 granted.
REQ-037 Async reset mid-grant: reset_n low between clock edges -> enable=0 and address=00 before the next edge; first post-reset grant is lowest-index.
